logic_gates_checker: RTL and testbench

- Self-checking response monitor for the two-input logic-gate block; it is the receiving end of that block's stimulus interface.
- Accepts (a,b) vectors over a valid/ready handshake and drives them onto the gate block's inputs.
- Waits a programmable settle time, then samples the seven gate outputs and compares them against the expected truth table.
- Accumulates pass/fail counts, input-combination coverage and first-failure diagnostics, so the gate block can be checked on silicon or in regression without a waveform viewer.

---
 rtl/logic_gates_checker.sv | 177 +++++++++++++++++
 tb/tb_logic_gates_checker.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_gates_checker.sv
// Response monitor for the two-input logic-gate block: drives (a,b) vectors, waits a settle
// time, compares the seven gate outputs. Optional macro LGC_STOP_ON_FAIL_EN ends a session at the first failure.
module logic_gates_checker #(
  parameter int SETTLE_CYCLES = 2,  // legal range 1..15
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             vec_valid,
  input  logic             vec_a,
  input  logic             vec_b,
  input  logic             vec_last,
  output logic             vec_ready,
  output logic             drive_a,
  output logic             drive_b,
  input  logic             y0,
  input  logic             y1,
  input  logic             y2,
  input  logic             y3,
  input  logic             y4,
  input  logic             y5,
  input  logic             y6,
  output logic             busy,
  output logic             done,
  output logic             err_flag,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [3:0]       cov,
  output logic [1:0]       first_fail_vec,
  output logic [6:0]       first_fail_mask
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_VEC,
    SETTLE,
    COMPARE,
    DONE
  } state_e;

  localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_e           state_q, state_d;
  logic             drive_a_q, drive_a_d;
  logic             drive_b_q, drive_b_d;
  logic             last_q, last_d;
  logic [3:0]       settle_q, settle_d;
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] fail_q, fail_d;
  logic [3:0]       cov_q, cov_d;
  logic             err_q, err_d;
  logic [1:0]       ff_vec_q, ff_vec_d;
  logic [6:0]       ff_mask_q, ff_mask_d;

  logic [6:0] y_obs;
  logic [6:0] y_exp;
  logic [6:0] mask;
  logic       end_session;

  assign y_obs = {y6, y5, y4, y3, y2, y1, y0};
  assign y_exp = {~drive_a_q,
                  ~(drive_a_q ^ drive_b_q),
                  drive_a_q ^ drive_b_q,
                  ~(drive_a_q | drive_b_q),
                  ~(drive_a_q & drive_b_q),
                  drive_a_q | drive_b_q,
                  drive_a_q & drive_b_q};
  assign mask  = y_obs ^ y_exp;

`ifdef LGC_STOP_ON_FAIL_EN
  assign end_session = last_q | (|mask);
`else
  assign end_session = last_q;
`endif

  always_comb begin
    // NOTE: every _d takes its current _q value first, so no branch can leave one unassigned and infer a latch.
    state_d   = state_q;
    drive_a_d = drive_a_q;
    drive_b_d = drive_b_q;
    last_d    = last_q;
    settle_d  = settle_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    cov_d     = cov_q;
    err_d     = err_q;
    ff_vec_d  = ff_vec_q;
    ff_mask_d = ff_mask_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          pass_d    = '0;
          fail_d    = '0;
          cov_d     = '0;
          err_d     = 1'b0;
          ff_vec_d  = '0;
          ff_mask_d = '0;
          state_d   = WAIT_VEC;
        end
      end
      WAIT_VEC: begin
        if (vec_valid) begin
          drive_a_d = vec_a;
          drive_b_d = vec_b;
          last_d    = vec_last;
          settle_d  = SETTLE_LOAD;
          state_d   = SETTLE;
        end
      end
      SETTLE: begin
        // Holding one extra cycle at 1 places the sample SETTLE_CYCLES+1 edges after acceptance.
        if (settle_q == 4'd1) state_d = COMPARE;
        else                  settle_d = settle_q - 4'd1;
      end
      COMPARE: begin
        if (mask == '0) begin
          if (pass_q != CNT_MAX) pass_d = pass_q + 1'b1;
        end else begin
          if (fail_q != CNT_MAX) fail_d = fail_q + 1'b1;
          err_d = 1'b1;
          if (!err_q) begin
            ff_vec_d  = {drive_a_q, drive_b_q};
            ff_mask_d = mask;
          end
        end
        cov_d[{drive_a_q, drive_b_q}] = 1'b1;
        state_d = end_session ? DONE : WAIT_VEC;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      drive_a_q <= 1'b0;
      drive_b_q <= 1'b0;
      last_q    <= 1'b0;
      settle_q  <= '0;
      pass_q    <= '0;
      fail_q    <= '0;
      cov_q     <= '0;
      err_q     <= 1'b0;
      ff_vec_q  <= '0;
      ff_mask_q <= '0;
    end else begin
      state_q   <= state_d;
      drive_a_q <= drive_a_d;
      drive_b_q <= drive_b_d;
      last_q    <= last_d;
      settle_q  <= settle_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      cov_q     <= cov_d;
      err_q     <= err_d;
      ff_vec_q  <= ff_vec_d;
      ff_mask_q <= ff_mask_d;
    end
  end

  assign vec_ready       = (state_q == WAIT_VEC);
  assign busy            = (state_q == WAIT_VEC) || (state_q == SETTLE) || (state_q == COMPARE);
  assign done            = (state_q == DONE);
  assign drive_a         = drive_a_q;
  assign drive_b         = drive_b_q;
  assign err_flag        = err_q;
  assign pass_cnt        = pass_q;
  assign fail_cnt        = fail_q;
  assign cov             = cov_q;
  assign first_fail_vec  = ff_vec_q;
  assign first_fail_mask = ff_mask_q;

endmodule

// File: tb/tb_logic_gates_checker.sv
// Bench for logic_gates_checker: table-driven sessions against a gate model with injectable
// faults, a scoreboard queue of accepted vectors, and a 2-bit-counter instance for saturation.
module tb_logic_gates_checker;

  localparam int S = 3;
`ifdef LGC_STOP_ON_FAIL_EN
  localparam bit STOP_EN = 1'b1;
`else
  localparam bit STOP_EN = 1'b0;
`endif

  typedef struct {
    logic       a;
    logic       b;
    logic       last;
    logic [6:0] mask;  // mismatch mask the checker should report for this vector
  } vec_t;

  logic clk = 1'b0;
  logic rst_n, start, vec_valid, vec_a, vec_b, vec_last;
  int   fault_mode;

  logic       vec_ready, drive_a, drive_b, busy, done, err_flag;
  logic [7:0] pass_cnt, fail_cnt;
  logic [3:0] cov;
  logic [1:0] first_fail_vec;
  logic [6:0] first_fail_mask;
  logic [6:0] y_m;

  logic       vec_ready_s, drive_a_s, drive_b_s, busy_s, done_s, err_s;
  logic [1:0] pass_s, fail_s;
  logic [3:0] cov_s;
  logic [1:0] ffv_s;
  logic [6:0] ffm_s;
  logic [6:0] y_s;

  int n_cmp = 0;
  int n_bad = 0;

  vec_t sb[$];
  vec_t cur[$];
  int         m_pass, m_fail;
  logic [3:0] m_cov;
  logic       m_err;
  logic [1:0] m_ffv;
  logic [6:0] m_ffm;

  always #5 clk = ~clk;

  // Gate block under observation; fault 1 = y4 stuck at 0, fault 2 = y6 inverted when a=1.
  function automatic logic [6:0] gate_model(input logic a, input logic b, input int fault);
    logic [6:0] y;
    y[0] = a & b;
    y[1] = a | b;
    y[2] = !(a & b);
    y[3] = !(a | b);
    y[4] = a ^ b;
    y[5] = !(a ^ b);
    y[6] = !a;
    if (fault == 1) y[4] = 1'b0;
    if (fault == 2 && a) y[6] = !y[6];
    return y;
  endfunction

  always_comb y_m = gate_model(drive_a, drive_b, fault_mode);
  always_comb y_s = gate_model(drive_a_s, drive_b_s, fault_mode);

  logic_gates_checker #(.SETTLE_CYCLES(S), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_valid(vec_valid),
    .vec_a(vec_a), .vec_b(vec_b), .vec_last(vec_last), .vec_ready(vec_ready),
    .drive_a(drive_a), .drive_b(drive_b),
    .y0(y_m[0]), .y1(y_m[1]), .y2(y_m[2]), .y3(y_m[3]), .y4(y_m[4]), .y5(y_m[5]), .y6(y_m[6]),
    .busy(busy), .done(done), .err_flag(err_flag), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .cov(cov), .first_fail_vec(first_fail_vec), .first_fail_mask(first_fail_mask)
  );

  logic_gates_checker #(.SETTLE_CYCLES(S), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_valid(vec_valid),
    .vec_a(vec_a), .vec_b(vec_b), .vec_last(vec_last), .vec_ready(vec_ready_s),
    .drive_a(drive_a_s), .drive_b(drive_b_s),
    .y0(y_s[0]), .y1(y_s[1]), .y2(y_s[2]), .y3(y_s[3]), .y4(y_s[4]), .y5(y_s[5]), .y6(y_s[6]),
    .busy(busy_s), .done(done_s), .err_flag(err_s), .pass_cnt(pass_s), .fail_cnt(fail_s),
    .cov(cov_s), .first_fail_vec(ffv_s), .first_fail_mask(ffm_s)
  );

  function automatic vec_t mk(input logic a, input logic b, input logic last, input logic [6:0] mask);
    vec_t v;
    v.a = a; v.b = b; v.last = last; v.mask = mask;
    return v;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    m_pass = 0; m_fail = 0; m_cov = '0; m_err = 1'b0; m_ffv = '0; m_ffm = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, 32'({vec_ready, drive_a, drive_b, busy, done, err_flag}), 32'd0);
    check({tag, "_data"}, 32'({pass_cnt, fail_cnt, cov, first_fail_vec, first_fail_mask}), 32'd0);
  endtask

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    clear_model();
    check("start_busy_ready", 32'({busy, vec_ready, done}), 32'b110);
    check("start_clear", 32'({pass_cnt, fail_cnt, cov, err_flag, first_fail_vec, first_fail_mask}), 32'd0);
    check("start_clear_sat", 32'({pass_s, fail_s, cov_s, err_s}), 32'd0);
    @(negedge clk); start = 1'b0;
  endtask

  // Present a vector, wait (bounded) for ready, push it at the accepting edge.
  task automatic send_vec(input vec_t v, input bit hold, output bit ok);
    int k;
    ok = 1'b0;
    @(negedge clk);
    vec_valid = 1'b1; vec_a = v.a; vec_b = v.b; vec_last = v.last;
    k = 0;
    while (!vec_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!vec_ready) begin
      check("ready_timeout", 32'(vec_ready), 32'd1);
      vec_valid = 1'b0;
      return;
    end
    @(posedge clk);
    sb.push_back(v);
    #1;
    check("drive_after_accept", 32'({drive_a, drive_b}), 32'({v.a, v.b}));
    check("ready_drops", 32'(vec_ready), 32'd0);
    if (!hold) begin
      @(negedge clk);
      vec_valid = 1'b0;
    end
    ok = 1'b1;
  endtask

  // Called right after the accepting edge; checks nothing moves before edge N+S+1, then scores.
  task automatic expect_result(output bit ended);
    vec_t e;
    ended = 1'b0;
    repeat (S) @(posedge clk);
    #1;
    check("pre_sample_cnt", 32'({pass_cnt, fail_cnt}), 32'({8'(m_pass), 8'(m_fail)}));
    check("pre_sample_ready", 32'(vec_ready), 32'd0);
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    if (e.mask == '0) m_pass++;
    else begin
      m_fail++;
      if (!m_err) begin
        m_ffv = {e.a, e.b};
        m_ffm = e.mask;
      end
      m_err = 1'b1;
    end
    m_cov[{e.a, e.b}] = 1'b1;
    check("pass_cnt", 32'(pass_cnt), 32'(sat(m_pass, 255)));
    check("fail_cnt", 32'(fail_cnt), 32'(sat(m_fail, 255)));
    check("cov", 32'(cov), 32'(m_cov));
    check("err_flag", 32'(err_flag), 32'(m_err));
    check("first_fail", 32'({first_fail_vec, first_fail_mask}), 32'({m_ffv, m_ffm}));
    check("sat_pass_cnt", 32'(pass_s), 32'(sat(m_pass, 3)));
    check("sat_fail_cnt", 32'(fail_s), 32'(sat(m_fail, 3)));
    ended = e.last || (STOP_EN && e.mask != '0);
    if (ended) check("end_state", 32'({done, busy, vec_ready}), 32'b100);
    else       check("mid_state", 32'({done, busy, vec_ready}), 32'b011);
  endtask

  task automatic run_session();
    bit ok, ended;
    for (int i = 0; i < cur.size(); i++) begin
      send_vec(cur[i], 1'b0, ok);
      if (!ok) return;
      expect_result(ended);
      if (ended) break;
    end
    check("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t good_q[$], y4_q[$], y6_q[$], sat_q[$];
    bit ok, ended;

    good_q.push_back(mk(0, 0, 0, 7'h00));
    good_q.push_back(mk(0, 1, 0, 7'h00));
    good_q.push_back(mk(1, 0, 0, 7'h00));
    good_q.push_back(mk(1, 1, 1, 7'h00));
    y4_q.push_back(mk(0, 0, 0, 7'b0000000));
    y4_q.push_back(mk(0, 1, 0, 7'b0010000));
    y4_q.push_back(mk(1, 0, 0, 7'b0010000));
    y4_q.push_back(mk(1, 1, 1, 7'b0000000));
    y6_q.push_back(mk(0, 0, 0, 7'b0000000));
    y6_q.push_back(mk(0, 1, 0, 7'b0000000));
    y6_q.push_back(mk(1, 0, 0, 7'b1000000));
    y6_q.push_back(mk(1, 1, 1, 7'b1000000));
    for (int i = 0; i < 6; i++)
      sat_q.push_back(mk(i[0], i[1], (i == 5), 7'h00));

    rst_n = 1'b0; start = 1'b0; vec_valid = 1'b0;
    vec_a = 1'b0; vec_b = 1'b0; vec_last = 1'b0; fault_mode = 0;
    clear_model();
    @(posedge clk); #1;
    check_all_zero("reset");
    @(negedge clk); rst_n = 1'b1;

    // Correct gates, full sweep.
    do_start();
    cur = good_q;
    run_session();
    repeat (3) @(posedge clk);
    #1;
    check("done_hold", 32'({done, busy, pass_cnt}), 32'({1'b1, 1'b0, 8'd4}));
    check("drive_hold", 32'({drive_a, drive_b}), 32'b11);

    // y4 stuck at 0.
    fault_mode = 1;
    do_start();
    cur = y4_q;
    run_session();

    // Valid held through the settle window: exactly one count; start ignored while busy.
    fault_mode = 0;
    do_start();
    send_vec(mk(1, 1, 0, 7'h00), 1'b1, ok);
    if (ok) expect_result(ended);
    @(negedge clk); vec_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("hold_single_count", 32'({pass_cnt, vec_ready}), 32'({8'd1, 1'b1}));
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    check("start_ignored_busy", 32'({pass_cnt, busy, vec_ready}), 32'({8'd1, 1'b1, 1'b1}));
    @(negedge clk); start = 1'b0;
    send_vec(mk(0, 0, 1, 7'h00), 1'b0, ok);
    if (ok) expect_result(ended);

    // Six passing vectors: 2-bit counter saturates at 3.
    do_start();
    cur = sat_q;
    run_session();
    check("sat_final", 32'({pass_s, pass_cnt}), 32'({2'd3, 8'd6}));

    // Reset in SETTLE of the third vector discards the session.
    do_start();
    cur = good_q;
    for (int i = 0; i < 2; i++) begin
      send_vec(cur[i], 1'b0, ok);
      if (ok) expect_result(ended);
    end
    send_vec(cur[2], 1'b0, ok);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    sb.delete();
    clear_model();
    @(negedge clk); rst_n = 1'b1;
    do_start();
    cur.delete();
    cur.push_back(mk(0, 1, 1, 7'h00));
    run_session();
    check("post_reset_session", 32'({pass_cnt, fail_cnt, cov}), 32'({8'd1, 8'd0, 4'b0010}));

    // y6 wrong for a=1; with the stop option the session ends after vector 10.
    fault_mode = 2;
    do_start();
    cur = y6_q;
    run_session();
    if (STOP_EN) check("stop_on_fail", 32'({done, pass_cnt, fail_cnt}), 32'({1'b1, 8'd2, 8'd1}));
    else         check("run_to_last", 32'({done, pass_cnt, fail_cnt}), 32'({1'b1, 8'd2, 8'd2}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
